// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped I-cache controller (fetch port, cache SRAM read/write port, burst refill port); define ICACHE_PERF_CNT_EN to add perf_hit_cnt/perf_miss_cnt
module icache_ctrl #(
  parameter int LINE_WORDS = 8,
  parameter int LINES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_addr,
  output logic        fetch_ready,
  output logic        fetch_data_valid,
  output logic [31:0] fetch_data,
  input  logic        flush,
  output logic        cache_read_en,
  output logic [31:0] cache_read_addr,
  input  logic [31:0] cache_read_data,
  output logic        cache_write_en,
  output logic [31:0] cache_write_addr,
  output logic [31:0] cache_write_data,
  output logic        mem_arvalid,
  output logic [31:0] mem_araddr,
  input  logic        mem_arready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rlast
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0] perf_hit_cnt,
  output logic [31:0] perf_miss_cnt
`endif
);
  localparam int OW = $clog2(LINE_WORDS);
  localparam int IW = $clog2(LINES);
  localparam int TW = 30 - OW - IW;
  localparam int BW = OW + 1;
  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_AR, REFILL, RESP} state_t;
  state_t state, state_n;
  logic [31:2] addr_q;
  logic [31:0] crit_q, line_base;
  logic [TW-1:0] tags [LINES];
  logic [LINES-1:0] valid;
  logic [BW-1:0] beat;
  logic [OW-1:0] off;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic flush_pend, crit_ok, hit, crit_now, full, got_crit;
  logic accept, ar_hs, beat_v, last_v;
  assign off = addr_q[OW+1:2];
  assign idx = addr_q[OW+IW+1:OW+2];
  assign tag = addr_q[31:OW+IW+2];
  assign line_base = {addr_q[31:OW+2], {(OW+2){1'b0}}};
  assign hit = valid[idx] && tags[idx] == tag;
  assign crit_now = beat == {1'b0, off};
  assign full = beat == BW'(LINE_WORDS - 1);
  assign got_crit = crit_ok || crit_now;
  always_comb begin
    state_n = state;
    fetch_ready = 1'b0;
    fetch_data_valid = 1'b0;
    fetch_data = '0;
    cache_read_en = 1'b0;
    cache_read_addr = '0;
    cache_write_en = 1'b0;
    cache_write_addr = '0;
    cache_write_data = '0;
    mem_arvalid = 1'b0;
    mem_araddr = '0;
    accept = 1'b0;
    ar_hs = 1'b0;
    beat_v = 1'b0;
    last_v = 1'b0;
    if (rst) begin
      case (state)
        IDLE: begin
          fetch_ready = 1'b1;
          accept = fetch_valid;
          cache_read_en = fetch_valid;
          cache_read_addr = fetch_valid ? fetch_addr : '0;
          state_n = fetch_valid ? LOOKUP : IDLE;
        end
        LOOKUP: begin
          fetch_data_valid = hit;
          fetch_data = hit ? cache_read_data : '0;
          state_n = hit ? IDLE : MISS_AR;
        end
        MISS_AR: begin
          mem_arvalid = 1'b1;
          mem_araddr = line_base;
          ar_hs = mem_arready;
          state_n = mem_arready ? REFILL : MISS_AR;
        end
        REFILL: begin
          beat_v = mem_rvalid;
          last_v = mem_rvalid && mem_rlast;
          cache_write_en = mem_rvalid && !beat[OW];
          cache_write_addr = cache_write_en ? {addr_q[31:OW+2], beat[OW-1:0], 2'b00} : '0;
          cache_write_data = cache_write_en ? mem_rdata : '0;
          state_n = !last_v ? REFILL : got_crit ? RESP : MISS_AR;
        end
        RESP: begin
          fetch_data_valid = 1'b1;
          fetch_data = crit_q;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      valid <= '0;
      beat <= '0;
      flush_pend <= 1'b0;
      crit_ok <= 1'b0;
    end else begin
      state <= state_n;
      flush_pend <= (state == LOOKUP) ? 1'b0 : flush_pend || (flush && (state == MISS_AR || state == REFILL));
      if (ar_hs) begin
        beat <= '0;
        crit_ok <= 1'b0;
      end else if (beat_v) begin
        beat <= beat + BW'(!beat[OW]);
        crit_ok <= got_crit;
      end
      if (flush) valid <= '0;
      else if (last_v) valid[idx] <= full && !flush_pend;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) addr_q <= fetch_addr[31:2];
    if (beat_v && crit_now) crit_q <= mem_rdata;
    if (last_v) tags[idx] <= tag;
  end
`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_hit_cnt <= '0;
      perf_miss_cnt <= '0;
    end else if (state == LOOKUP) begin
      if (hit) perf_hit_cnt <= perf_hit_cnt + 32'(perf_hit_cnt != '1);
      else perf_miss_cnt <= perf_miss_cnt + 32'(perf_miss_cnt != '1);
    end
  end
`endif
endmodule
